// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS32 fetch front end.
// Trap support in pc_fetch_ctrl is enabled by defining MISALIGN_TRAP_EN.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetchState_t;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } nextPcSel_t;

  localparam logic [XLEN-1:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [XLEN-1:0] EXC_VECTOR_DEF = 32'h0000_0180;

  function automatic logic isMisaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Priority next-PC selector (jr > jump > branch > sequential) with misaligned-target flag.
module next_pc_mux
  import mips_pkg::*;
#(
  parameter bit TRAP_EN = 1'b0
) (
  input  logic [XLEN-1:0] pcPlus4,
  input  logic            branchTaken,
  input  logic [XLEN-1:0] branchTarget,
  input  logic            jump,
  input  logic [XLEN-1:0] jumpTarget,
  input  logic            jr,
  input  logic [XLEN-1:0] jrTarget,
  output logic [XLEN-1:0] nextPc,
  output logic            misaligned
);

  nextPcSel_t sel;

  always_comb begin
    sel        = SEL_SEQ;
    nextPc     = pcPlus4;
    misaligned = 1'b0;
    if (jr)               sel = SEL_JR;
    else if (jump)        sel = SEL_J;
    else if (branchTaken) sel = SEL_BR;
    case (sel)
      SEL_JR:  nextPc = jrTarget;
      SEL_J:   nextPc = jumpTarget;
      SEL_BR:  nextPc = branchTarget;
      default: nextPc = pcPlus4;
    endcase
    // Sequential PC comes from the adder and is aligned whenever pc is.
    misaligned = TRAP_EN && (sel != SEL_SEQ) && isMisaligned(nextPc);
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register, fetch FSM and retired-instruction counter for the single-cycle core.
// Define MISALIGN_TRAP_EN to redirect misaligned targets to EXC_VECTOR and pulse misalign_err.
module pc_fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        stall,
  input  logic        halt,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic        instr_valid,
  output logic [31:0] instr_count,
  output logic        halted,
  output logic        misalign_err
);

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  fetchState_t     state, stateNext;
  logic            accept;
  logic [XLEN-1:0] nextPc;
  logic            misaligned;

  next_pc_mux #(.TRAP_EN(TRAP_EN)) uNextPcMux (
    .pcPlus4     (pc_plus4),
    .branchTaken (branch_taken),
    .branchTarget(branch_target),
    .jump        (jump),
    .jumpTarget  (jump_target),
    .jr          (jr),
    .jrTarget    (jr_target),
    .nextPc      (nextPc),
    .misaligned  (misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= BOOT;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    accept      = 1'b0;
    case (state)
      BOOT:  stateNext = FETCH;
      FETCH: begin
        imem_req    = 1'b1;
        instr_valid = imem_ready;
        accept      = imem_ready & ~stall;
        if (accept && halt) stateNext = HALTED;
      end
      HALTED:  halted = 1'b1;
      default: stateNext = BOOT;
    endcase
  end

  // The instruction retires on accept, including a halting or trapping one.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      instr_count <= 32'd0;
    end else if (accept) begin
      pc          <= misaligned ? EXC_VECTOR : nextPc;
      instr_count <= instr_count + 32'd1;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) misalign_err <= 1'b0;
    else       misalign_err <= accept & misaligned;
  end
`else
  assign misalign_err = misaligned;
`endif

endmodule
